// File: rtl/mem_dbus_ctrl_pkg.sv
// Package for the MEM-stage data-bus controller.
// Holds the load/store AluOp codes, pipeline stall constants, the FSM state type and
// small decode helpers shared by mem_dbus_ctrl and mem_load_align.
package mem_dbus_ctrl_pkg;

   // Load/store AluOp codes (OpenMIPS encoding)
   localparam logic [7:0] OpLb  = 8'b1110_0000;
   localparam logic [7:0] OpLh  = 8'b1110_0001;
   localparam logic [7:0] OpLw  = 8'b1110_0011;
   localparam logic [7:0] OpLbu = 8'b1110_0100;
   localparam logic [7:0] OpLhu = 8'b1110_0101;
   localparam logic [7:0] OpSb  = 8'b1110_1000;
   localparam logic [7:0] OpSh  = 8'b1110_1001;
   localparam logic [7:0] OpSw  = 8'b1110_1011;

   localparam logic [4:0] NopRegAddr = 5'd0;
   localparam logic       Stop       = 1'b1;
   localparam logic       NoStop     = 1'b0;

   // Access sizes
   localparam logic [1:0] SzByte = 2'd0;
   localparam logic [1:0] SzHalf = 2'd1;
   localparam logic [1:0] SzWord = 2'd2;

   typedef enum logic [2:0] {
      StIdle = 3'b001,
      StReq  = 3'b010,
      StDone = 3'b100
   } state_e;

   typedef struct packed {
      logic       is_load;
      logic       is_store;
      logic [1:0] size;
   } mem_op_t;

   function automatic mem_op_t decode_op(input logic [7:0] op);
      mem_op_t d;
      d = '{is_load: 1'b0, is_store: 1'b0, size: SzWord};
      case (op)
         OpLb, OpLbu: begin d.is_load  = 1'b1; d.size = SzByte; end
         OpLh, OpLhu: begin d.is_load  = 1'b1; d.size = SzHalf; end
         OpLw:        begin d.is_load  = 1'b1; d.size = SzWord; end
         OpSb:        begin d.is_store = 1'b1; d.size = SzByte; end
         OpSh:        begin d.is_store = 1'b1; d.size = SzHalf; end
         OpSw:        begin d.is_store = 1'b1; d.size = SzWord; end
         default:     ;
      endcase
      return d;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      if (size == SzHalf) return off[0];
      if (size == SzWord) return off != 2'b00;
      return 1'b0;
   endfunction

   // Big-endian lanes: offset 0 is bits 31:24 (sel bit 3)
   function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
      if (size == SzByte) return 4'b1000 >> off;
      if (size == SzHalf) return off[1] ? 4'b0011 : 4'b1100;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
      if (size == SzByte) return {4{d[7:0]}};
      if (size == SzHalf) return {2{d[15:0]}};
      return d;
   endfunction

endpackage

// File: rtl/mem_dbus_ctrl_load_align.sv
// mem_load_align: combinational load data alignment and extension (big-endian lanes).
// Ports:
//   aluop_i  load op code
//   off_i    byte offset addr[1:0] of the access
//   rdata_i  raw bus read word
//   data_o   selected byte/half/word, sign- or zero-extended to 32 bits
module mem_load_align
   import mem_dbus_ctrl_pkg::*;
(
   input  logic [7:0]  aluop_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] data_o
);

   logic [1:0]  lane;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      lane   = 2'd3 - off_i;
      byte_v = rdata_i[{lane, 3'b000} +: 8];
      half_v = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
      case (aluop_i)
         OpLb:    data_o = {{24{byte_v[7]}}, byte_v};
         OpLbu:   data_o = {24'd0, byte_v};
         OpLh:    data_o = {{16{half_v[15]}}, half_v};
         OpLhu:   data_o = {16'd0, half_v};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_dbus_ctrl.sv
// mem_dbus_ctrl: MEM-stage data-bus controller. Runs one req/ack transaction per load/store,
// stalls the pipeline until it completes, and presents write-back fields to mem_wb.
// Ports:
//   clk, rst                    clock, async active-high reset
//   stall[5:0], flush           pipeline control (stall[4] holds MEM)
//   mem_*_i                     op, address, store data and write-back fields from EX/MEM
//   mem_wd_o/mem_wreg_o/mem_wdata_o  write-back fields to mem_wb
//   stallreq, misalign, bus_err status to the pipeline
//   dbus_*                      data-bus master interface
module mem_dbus_ctrl
   import mem_dbus_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        flush,
   input  logic [7:0]  mem_aluop_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_reg2_i,
   input  logic [4:0]  mem_wd_i,
   input  logic        mem_wreg_i,
   input  logic [31:0] mem_wdata_i,
   output logic [4:0]  mem_wd_o,
   output logic        mem_wreg_o,
   output logic [31:0] mem_wdata_o,
   output logic        stallreq,
   output logic        misalign,
   output logic        bus_err,
   output logic        dbus_req_o,
   output logic        dbus_we_o,
   output logic [31:0] dbus_addr_o,
   output logic [3:0]  dbus_sel_o,
   output logic [31:0] dbus_wdata_o,
   input  logic        dbus_ack_i,
   input  logic [31:0] dbus_rdata_i
);

   localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic        drop_q, drop_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] bwdata_q, bwdata_d;
   logic [7:0]  op_q, op_d;
   logic [1:0]  off_q, off_d;
   logic [4:0]  wd_q, wd_d;
   logic        wreg_q, wreg_d;
   logic [31:0] data_q, data_d;
   logic        bus_err_q, bus_err_d;

   mem_op_t     dec;
   logic        is_mem;
   logic        mis;
   logic        cnt_hit;
   logic [31:0] align_data;

   // Only stall[4] concerns this stage
   logic        unused_stall;
   assign unused_stall = ^{stall[5], stall[3:0]};

   mem_load_align u_align (
      .aluop_i (op_q),
      .off_i   (off_q),
      .rdata_i (dbus_rdata_i),
      .data_o  (align_data)
   );

   always_comb begin
      dec     = decode_op(mem_aluop_i);
      is_mem  = dec.is_load | dec.is_store;
      mis     = is_mem && is_misaligned(dec.size, mem_addr_i[1:0]);
      cnt_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

      state_d   = state_q;
      cnt_d     = cnt_q;
      drop_d    = drop_q;
      req_d     = req_q;
      we_d      = we_q;
      sel_d     = sel_q;
      addr_d    = addr_q;
      bwdata_d  = bwdata_q;
      op_d      = op_q;
      off_d     = off_q;
      wd_d      = wd_q;
      wreg_d    = wreg_q;
      data_d    = data_q;
      bus_err_d = 1'b0;

      mem_wd_o    = mem_wd_i;
      mem_wreg_o  = mem_wreg_i;
      mem_wdata_o = mem_wdata_i;
      stallreq    = 1'b0;
      misalign    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (flush) begin
               mem_wd_o    = NopRegAddr;
               mem_wreg_o  = 1'b0;
               mem_wdata_o = '0;
            end else if (mis) begin
               misalign   = 1'b1;
               mem_wreg_o = 1'b0;
            end else if (is_mem) begin
               stallreq   = 1'b1;
               mem_wreg_o = 1'b0;
               state_d    = StReq;
               req_d      = 1'b1;
               we_d       = dec.is_store;
               sel_d      = lane_sel(dec.size, mem_addr_i[1:0]);
               addr_d     = {mem_addr_i[31:2], 2'b00};
               bwdata_d   = dec.is_store ? store_data(dec.size, mem_reg2_i) : '0;
               op_d       = mem_aluop_i;
               off_d      = mem_addr_i[1:0];
               wd_d       = mem_wd_i;
               wreg_d     = dec.is_load & mem_wreg_i;
               data_d     = '0;
               cnt_d      = '0;
               drop_d     = 1'b0;
            end
         end
         StReq: begin
            mem_wd_o    = wd_q;
            mem_wreg_o  = 1'b0;
            mem_wdata_o = data_q;
            // A flushed access still finishes on the bus but no longer holds the pipeline
            drop_d      = drop_q | flush;
            stallreq    = ~drop_d;
            if (TIMEOUT != 0) cnt_d = cnt_q + CntW'(1);
            if (dbus_ack_i) begin
               req_d   = 1'b0;
               if (!we_q) data_d = align_data;
               state_d = drop_d ? StIdle : StDone;
            end else if (cnt_hit) begin
               req_d     = 1'b0;
               bus_err_d = 1'b1;
               wreg_d    = 1'b0;
               state_d   = drop_d ? StIdle : StDone;
            end
         end
         StDone: begin
            mem_wd_o    = wd_q;
            mem_wreg_o  = wreg_q;
            mem_wdata_o = data_q;
            if (flush) begin
               mem_wd_o    = NopRegAddr;
               mem_wreg_o  = 1'b0;
               mem_wdata_o = '0;
               state_d     = StIdle;
            end else if (stall[4] == NoStop) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         drop_q    <= 1'b0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         sel_q     <= 4'b0000;
         addr_q    <= '0;
         bwdata_q  <= '0;
         op_q      <= 8'd0;
         off_q     <= 2'd0;
         wd_q      <= NopRegAddr;
         wreg_q    <= 1'b0;
         data_q    <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         drop_q    <= drop_d;
         req_q     <= req_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         addr_q    <= addr_d;
         bwdata_q  <= bwdata_d;
         op_q      <= op_d;
         off_q     <= off_d;
         wd_q      <= wd_d;
         wreg_q    <= wreg_d;
         data_q    <= data_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign dbus_req_o   = req_q;
   assign dbus_we_o    = we_q;
   assign dbus_addr_o  = addr_q;
   assign dbus_sel_o   = sel_q;
   assign dbus_wdata_o = bwdata_q;
   assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Directed bench for mem_dbus_ctrl: table of single accesses plus hand-written sequences for
// reset, timeout, flush in REQ/IDLE and asynchronous reset mid-access.
module tb_mem_dbus_ctrl;
   import mem_dbus_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = '0;
   logic        flush = 1'b0;
   logic [7:0]  mem_aluop_i = '0;
   logic [31:0] mem_addr_i = '0;
   logic [31:0] mem_reg2_i = '0;
   logic [4:0]  mem_wd_i = '0;
   logic        mem_wreg_i = 1'b0;
   logic [31:0] mem_wdata_i = '0;
   logic [4:0]  mem_wd_o;
   logic        mem_wreg_o;
   logic [31:0] mem_wdata_o;
   logic        stallreq, misalign, bus_err;
   logic        dbus_req_o, dbus_we_o;
   logic [31:0] dbus_addr_o, dbus_wdata_o;
   logic [3:0]  dbus_sel_o;
   logic        dbus_ack_i = 1'b0;
   logic [31:0] dbus_rdata_i = '0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_dbus_ctrl #(.TIMEOUT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .flush        (flush),
      .mem_aluop_i  (mem_aluop_i),
      .mem_addr_i   (mem_addr_i),
      .mem_reg2_i   (mem_reg2_i),
      .mem_wd_i     (mem_wd_i),
      .mem_wreg_i   (mem_wreg_i),
      .mem_wdata_i  (mem_wdata_i),
      .mem_wd_o     (mem_wd_o),
      .mem_wreg_o   (mem_wreg_o),
      .mem_wdata_o  (mem_wdata_o),
      .stallreq     (stallreq),
      .misalign     (misalign),
      .bus_err      (bus_err),
      .dbus_req_o   (dbus_req_o),
      .dbus_we_o    (dbus_we_o),
      .dbus_addr_o  (dbus_addr_o),
      .dbus_sel_o   (dbus_sel_o),
      .dbus_wdata_o (dbus_wdata_o),
      .dbus_ack_i   (dbus_ack_i),
      .dbus_rdata_i (dbus_rdata_i)
   );

   // kind: 0 = bus access, 1 = misaligned, 2 = non-memory pass-through
   typedef struct {
      int          kind;
      logic [7:0]  op;
      logic [31:0] addr;
      logic [31:0] reg2;
      logic [31:0] rdata;
      logic [3:0]  sel;
      logic        we;
      logic [31:0] bwdata;
      logic [31:0] wdata;
      logic        wreg;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(int k, logic [7:0] op, logic [31:0] addr, logic [31:0] reg2,
                               logic [31:0] rdata, logic [3:0] sel, logic we,
                               logic [31:0] bwdata, logic [31:0] wdata, logic wreg);
      vec_t v;
      v.kind = k; v.op = op; v.addr = addr; v.reg2 = reg2; v.rdata = rdata; v.sel = sel;
      v.we = we; v.bwdata = bwdata; v.wdata = wdata; v.wreg = wreg;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
      mem_aluop_i = op; mem_addr_i = addr; mem_reg2_i = reg2;
      mem_wd_i = wd; mem_wreg_i = wreg; mem_wdata_i = wdata;
   endtask

   task automatic drive_nop();
      drive(8'h00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
   endtask

   initial begin
      vecs[0]  = mk(0, OpLw,  32'h100, 32'h0, 32'hDEADBEEF, 4'b1111, 0, 32'h0, 32'hDEADBEEF, 1);
      vecs[1]  = mk(0, OpLb,  32'h103, 32'h0, 32'h112233F0, 4'b0001, 0, 32'h0, 32'hFFFFFFF0, 1);
      vecs[2]  = mk(0, OpLbu, 32'h103, 32'h0, 32'h112233F0, 4'b0001, 0, 32'h0, 32'h000000F0, 1);
      vecs[3]  = mk(0, OpLh,  32'h102, 32'h0, 32'h12348765, 4'b0011, 0, 32'h0, 32'hFFFF8765, 1);
      vecs[4]  = mk(0, OpLhu, 32'h100, 32'h0, 32'h87651234, 4'b1100, 0, 32'h0, 32'h00008765, 1);
      vecs[5]  = mk(0, OpLb,  32'h100, 32'h0, 32'h7F000000, 4'b1000, 0, 32'h0, 32'h0000007F, 1);
      vecs[6]  = mk(0, OpSh,  32'h202, 32'h0000ABCD, 32'h0, 4'b0011, 1, 32'hABCDABCD, 32'h0, 0);
      vecs[7]  = mk(0, OpSb,  32'h301, 32'h123456A5, 32'h0, 4'b0100, 1, 32'hA5A5A5A5, 32'h0, 0);
      vecs[8]  = mk(0, OpSw,  32'h404, 32'hCAFEF00D, 32'h0, 4'b1111, 1, 32'hCAFEF00D, 32'h0, 0);
      vecs[9]  = mk(1, OpLw,  32'h101, 32'h0, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 0);
      vecs[10] = mk(1, OpSh,  32'h203, 32'h0, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 0);
      vecs[11] = mk(1, OpLhu, 32'h105, 32'h0, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 0);
      vecs[12] = mk(1, OpSw,  32'h402, 32'h0, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 0);
      vecs[13] = mk(2, 8'b0010_0101, 32'h0, 32'h0, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 1);

      // Reset state
      #12;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_req", 32'(dbus_req_o), 32'd0);
      check("rst_we", 32'(dbus_we_o), 32'd0);
      check("rst_sel", 32'(dbus_sel_o), 32'd0);
      check("rst_addr", dbus_addr_o, 32'd0);
      check("rst_bwdata", dbus_wdata_o, 32'd0);
      check("rst_bus_err", 32'(bus_err), 32'd0);
      check("rst_stallreq", 32'(stallreq), 32'd0);
      tick();

      // Table of single accesses
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].op, vecs[i].addr, vecs[i].reg2, 5'(i + 1), 1'b1, 32'h5555_0000 + i);
         #1;
         case (vecs[i].kind)
            0: begin
               check($sformatf("v%0d_idle_stall", i), 32'(stallreq), 32'd1);
               check($sformatf("v%0d_idle_mis", i), 32'(misalign), 32'd0);
               tick();
               check($sformatf("v%0d_req", i), 32'(dbus_req_o), 32'd1);
               check($sformatf("v%0d_req_stall", i), 32'(stallreq), 32'd1);
               check($sformatf("v%0d_we", i), 32'(dbus_we_o), 32'(vecs[i].we));
               check($sformatf("v%0d_sel", i), 32'(dbus_sel_o), 32'(vecs[i].sel));
               check($sformatf("v%0d_addr", i), dbus_addr_o, {vecs[i].addr[31:2], 2'b00});
               check($sformatf("v%0d_req_wreg", i), 32'(mem_wreg_o), 32'd0);
               if (vecs[i].we)
                  check($sformatf("v%0d_bwdata", i), dbus_wdata_o, vecs[i].bwdata);
               dbus_ack_i = 1'b1;
               dbus_rdata_i = vecs[i].rdata;
               tick();
               dbus_ack_i = 1'b0;
               dbus_rdata_i = 32'h0;
               #1;
               check($sformatf("v%0d_done_req", i), 32'(dbus_req_o), 32'd0);
               check($sformatf("v%0d_done_stall", i), 32'(stallreq), 32'd0);
               check($sformatf("v%0d_done_wreg", i), 32'(mem_wreg_o), 32'(vecs[i].wreg));
               check($sformatf("v%0d_done_wd", i), 32'(mem_wd_o), i + 1);
               if (!vecs[i].we)
                  check($sformatf("v%0d_done_wdata", i), mem_wdata_o, vecs[i].wdata);
               drive_nop();
               tick();
            end
            1: begin
               check($sformatf("v%0d_mis", i), 32'(misalign), 32'd1);
               check($sformatf("v%0d_mis_stall", i), 32'(stallreq), 32'd0);
               check($sformatf("v%0d_mis_wreg", i), 32'(mem_wreg_o), 32'd0);
               tick();
               check($sformatf("v%0d_mis_noreq", i), 32'(dbus_req_o), 32'd0);
            end
            default: begin
               check($sformatf("v%0d_pt_stall", i), 32'(stallreq), 32'd0);
               check($sformatf("v%0d_pt_wreg", i), 32'(mem_wreg_o), 32'd1);
               check($sformatf("v%0d_pt_wd", i), 32'(mem_wd_o), i + 1);
               check($sformatf("v%0d_pt_wdata", i), mem_wdata_o, 32'h5555_0000 + i);
               tick();
               check($sformatf("v%0d_pt_noreq", i), 32'(dbus_req_o), 32'd0);
            end
         endcase
         drive_nop();
      end

      // Timeout: no ack, req held four cycles, then bus_err pulse in DONE
      drive(OpLw, 32'h500, 32'h0, 5'd3, 1'b1, 32'h0);
      tick();
      drive_nop();
      for (int j = 0; j < 4; j++) begin
         check($sformatf("to_req%0d", j), 32'(dbus_req_o), 32'd1);
         check($sformatf("to_noerr%0d", j), 32'(bus_err), 32'd0);
         tick();
      end
      check("to_req_drop", 32'(dbus_req_o), 32'd0);
      check("to_bus_err", 32'(bus_err), 32'd1);
      check("to_wreg", 32'(mem_wreg_o), 32'd0);
      check("to_stall", 32'(stallreq), 32'd0);
      stall = 6'b010000;
      dbus_ack_i = 1'b1;
      tick();
      check("to_err_pulse", 32'(bus_err), 32'd0);
      check("to_hold_done_wd", 32'(mem_wd_o), 32'd3);
      check("to_ack_ignored", 32'(dbus_req_o), 32'd0);
      stall = 6'b0;
      dbus_ack_i = 1'b0;
      tick();
      check("to_back_idle_wd", 32'(mem_wd_o), 32'd0);
      check("to_idle_stall", 32'(stallreq), 32'd0);

      // Flush while in REQ: bus cycle completes, no write-back, straight to IDLE
      drive(OpLw, 32'h600, 32'h0, 5'd7, 1'b1, 32'h0);
      tick();
      flush = 1'b1;
      drive_nop();
      #1;
      check("fl_req_held", 32'(dbus_req_o), 32'd1);
      check("fl_stall_drop", 32'(stallreq), 32'd0);
      tick();
      flush = 1'b0;
      #1;
      check("fl_req_held2", 32'(dbus_req_o), 32'd1);
      check("fl_stall_drop2", 32'(stallreq), 32'd0);
      tick();
      check("fl_req_held3", 32'(dbus_req_o), 32'd1);
      tick();
      dbus_ack_i = 1'b1;
      dbus_rdata_i = 32'h12345678;
      drive(8'b0010_0101, 32'h0, 32'h0, 5'd9, 1'b1, 32'hA5A5_0009);
      tick();
      dbus_ack_i = 1'b0;
      #1;
      check("fl_req_done", 32'(dbus_req_o), 32'd0);
      check("fl_idle_wd", 32'(mem_wd_o), 32'd9);
      check("fl_idle_wreg", 32'(mem_wreg_o), 32'd1);
      check("fl_idle_wdata", mem_wdata_o, 32'hA5A5_0009);
      check("fl_idle_stall", 32'(stallreq), 32'd0);
      drive_nop();
      tick();

      // Flush in IDLE with a load present: NOP out, no bus access
      flush = 1'b1;
      drive(OpLw, 32'h100, 32'h0, 5'd4, 1'b1, 32'h77);
      #1;
      check("fi_stall", 32'(stallreq), 32'd0);
      check("fi_wd", 32'(mem_wd_o), 32'd0);
      check("fi_wreg", 32'(mem_wreg_o), 32'd0);
      tick();
      check("fi_noreq", 32'(dbus_req_o), 32'd0);
      flush = 1'b0;
      drive_nop();
      tick();

      // Asynchronous reset in the middle of REQ drops req immediately
      drive(OpLw, 32'h700, 32'h0, 5'd5, 1'b1, 32'h0);
      tick();
      drive_nop();
      check("ar_req", 32'(dbus_req_o), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("ar_req_drop", 32'(dbus_req_o), 32'd0);
      check("ar_addr", dbus_addr_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("ar_idle_req", 32'(dbus_req_o), 32'd0);
      check("ar_idle_stall", 32'(stallreq), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
